cr_xp10_decomp_fhp_tlv_rdr: RTL and testbench

CR_XP10_DECOMP_FHP_TLV_RDR -- requirements
Module: cr_xp10_decomp_fhp_tlv_rdr

---
 rtl/cr_structs.sv | 11 +
 rtl/cr_xp10_decompPKG.sv | 29 ++
 rtl/cr_xp10_decomp_fhp_skid.sv | 62 ++++++
 rtl/cr_xp10_decomp_fhp_tlv_rdr.sv | 185 ++++++++++++++++++
 tb/tb_cr_xp10_decomp_fhp_tlv_rdr.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cr_structs.sv
// Shared interface structs; tlvp_if_bus_t is the show-ahead pass-through TLV word.
package cr_structs;

   typedef struct packed {
      logic        sot;
      logic        eot;
      logic [7:0]  typen;
      logic [63:0] tdata;
   } tlvp_if_bus_t;

endpackage

// File: rtl/cr_xp10_decompPKG.sv
// XP10 decompressor types used by the FHP TLV reader: FSM states, header TLV type, skid entry.
package cr_xp10_decompPKG;

   localparam logic [7:0] FHP_HDR_TLV_TYPE = 8'd5;

   typedef enum logic [1:0] {
      FHP_IDLE,
      FHP_FWD,
      FHP_HDR,
      FHP_DROP
   } fhp_state_e;

   typedef struct packed {
      logic [63:0] data;
      logic        sot;
      logic        eot;
      logic [7:0]  typen;
   } fhp_skid_entry_t;

   function automatic fhp_skid_entry_t fhp_tlv_to_entry(input cr_structs::tlvp_if_bus_t t);
      fhp_skid_entry_t e;
      e.data  = t.tdata;
      e.sot   = t.sot;
      e.eot   = t.eot;
      e.typen = t.typen;
      return e;
   endfunction

endpackage

// File: rtl/cr_xp10_decomp_fhp_skid.sv
// Two-entry output skid buffer for the FHP TLV reader; entry 0 is always the head and
// drives the output registers directly.
module cr_xp10_decomp_fhp_skid
   import cr_xp10_decompPKG::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  fhp_skid_entry_t push_entry,
   input  logic            pop_ready,
   output logic            out_valid,
   output fhp_skid_entry_t out_entry,
   output logic            full
);

   logic [1:0]      count_q, count_d, count_kept;
   fhp_skid_entry_t ent0_q, ent0_d, ent1_q, ent1_d;
   logic            pop, push_ok;

   assign full      = (count_q == 2'(DEPTH));
   assign out_valid = (count_q != 2'd0);
   assign out_entry = ent0_q;
   assign pop       = out_valid & pop_ready;
   // A push into a full buffer is refused even when a pop happens in the same cycle.
   assign push_ok   = push & ~full;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      ent0_d     = ent0_q;
      ent1_d     = ent1_q;
      count_kept = count_q - {1'b0, pop};
      if (pop) begin
         ent0_d = ent1_q;
      end
      if (push_ok) begin
         if (count_kept == 2'd0) begin
            ent0_d = push_entry;
         end else begin
            ent1_d = push_entry;
         end
      end
      count_d = count_kept + {1'b0, push_ok};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         // NOTE: the entries are reset because entry 0 is a top-level output that must read 0 in reset.
         ent0_q  <= '0;
         ent1_q  <= '0;
      end else begin
         count_q <= count_d;
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
      end
   end

endmodule

// File: rtl/cr_xp10_decomp_fhp_tlv_rdr.sv
// FHP TLV reader: captures the frame-header TLV, forwards all other TLVs through a skid buffer.
// Optional statistics counters are enabled with CR_XP10_DECOMP_FHP_STATS_EN.
module cr_xp10_decomp_fhp_tlv_rdr
   import cr_structs::*;
   import cr_xp10_decompPKG::*;
#(
   parameter logic [7:0] HDR_TLV_TYPE = FHP_HDR_TLV_TYPE,
   parameter int         SKID_DEPTH   = 2
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  tlvp_if_bus_t  fhp_tlvp_pt_tlv,
   input  logic          fhp_tlvp_pt_empty,
   output logic          fhp_tlvp_pt_rd,
   output logic          fhp_out_valid,
   input  logic          fhp_out_ready,
   output logic [63:0]   fhp_out_data,
   output logic          fhp_out_sot,
   output logic          fhp_out_eot,
   output logic [7:0]    fhp_out_type,
   output logic [127:0]  fhp_frm_hdr,
   output logic          fhp_frm_hdr_valid,
   output logic          fhp_proto_error
`ifdef CR_XP10_DECOMP_FHP_STATS_EN
   ,
   output logic [31:0]   fhp_stat_hdr_cnt,
   output logic [31:0]   fhp_stat_err_cnt,
   output logic [31:0]   fhp_stat_word_cnt
`endif
);

   fhp_state_e      state_q, state_d;
   logic            hdr_idx_q, hdr_idx_d;
   logic [127:0]    frm_hdr_q, frm_hdr_d;
   logic            hdr_vld_q, hdr_vld_d;
   logic            err_q, err_d;
   logic            run_q;
   logic            rd, needs_slot, hdr_type, as_idle;
   logic            skid_push, skid_full, skid_valid;
   fhp_skid_entry_t skid_in, skid_out;

   assign hdr_type = (fhp_tlvp_pt_tlv.typen == HDR_TLV_TYPE);
   // Any word that could be pushed needs a free slot, including a new TLV that aborts a header.
   assign needs_slot = (state_q == FHP_IDLE) || (state_q == FHP_FWD) ||
                       ((state_q == FHP_HDR) && fhp_tlvp_pt_tlv.sot && !hdr_type);
   assign rd             = run_q & ~fhp_tlvp_pt_empty & (~needs_slot | ~skid_full);
   assign fhp_tlvp_pt_rd = rd;
   assign skid_in        = fhp_tlv_to_entry(fhp_tlvp_pt_tlv);

   always_comb begin
      state_d   = state_q;
      hdr_idx_d = hdr_idx_q;
      frm_hdr_d = frm_hdr_q;
      hdr_vld_d = 1'b0;
      err_d     = 1'b0;
      skid_push = 1'b0;
      as_idle   = 1'b0;
      if (rd) begin
         unique case (state_q)
            FHP_IDLE: as_idle = 1'b1;
            FHP_FWD: begin
               if (fhp_tlvp_pt_tlv.sot) begin
                  err_d   = 1'b1;
                  as_idle = 1'b1;
               end else begin
                  skid_push = 1'b1;
                  if (fhp_tlvp_pt_tlv.eot) state_d = FHP_IDLE;
               end
            end
            FHP_HDR: begin
               if (fhp_tlvp_pt_tlv.sot) begin
                  err_d   = 1'b1;
                  as_idle = 1'b1;
               end else if (!hdr_idx_q) begin
                  frm_hdr_d[63:0] = fhp_tlvp_pt_tlv.tdata;
                  if (fhp_tlvp_pt_tlv.eot) begin
                     err_d   = 1'b1;
                     state_d = FHP_IDLE;
                  end else begin
                     hdr_idx_d = 1'b1;
                  end
               end else begin
                  frm_hdr_d[127:64] = fhp_tlvp_pt_tlv.tdata;
                  if (fhp_tlvp_pt_tlv.eot) begin
                     hdr_vld_d = 1'b1;
                     state_d   = FHP_IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = FHP_DROP;
                  end
               end
            end
            FHP_DROP: if (fhp_tlvp_pt_tlv.eot) state_d = FHP_IDLE;
            default:  state_d = FHP_IDLE;
         endcase

         // Start-of-TLV handling, shared by IDLE and by the abort path out of FWD/HDR.
         if (as_idle) begin
            if (!fhp_tlvp_pt_tlv.sot) begin
               err_d   = 1'b1;
               state_d = fhp_tlvp_pt_tlv.eot ? FHP_IDLE : FHP_DROP;
            end else if (hdr_type) begin
               hdr_idx_d = 1'b0;
               if (fhp_tlvp_pt_tlv.eot) begin
                  err_d   = 1'b1;
                  state_d = FHP_IDLE;
               end else begin
                  state_d = FHP_HDR;
               end
            end else begin
               skid_push = 1'b1;
               state_d   = fhp_tlvp_pt_tlv.eot ? FHP_IDLE : FHP_FWD;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= 1'b0;
         state_q   <= FHP_IDLE;
         hdr_idx_q <= 1'b0;
         frm_hdr_q <= '0;
         hdr_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         run_q     <= 1'b1;
         state_q   <= state_d;
         hdr_idx_q <= hdr_idx_d;
         frm_hdr_q <= frm_hdr_d;
         hdr_vld_q <= hdr_vld_d;
         err_q     <= err_d;
      end
   end

   cr_xp10_decomp_fhp_skid #(
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (skid_push),
      .push_entry (skid_in),
      .pop_ready  (fhp_out_ready),
      .out_valid  (skid_valid),
      .out_entry  (skid_out),
      .full       (skid_full)
   );

   assign fhp_out_valid     = skid_valid;
   assign fhp_out_data      = skid_out.data;
   assign fhp_out_sot       = skid_out.sot;
   assign fhp_out_eot       = skid_out.eot;
   assign fhp_out_type      = skid_out.typen;
   assign fhp_frm_hdr       = frm_hdr_q;
   assign fhp_frm_hdr_valid = hdr_vld_q;
   assign fhp_proto_error   = err_q;

`ifdef CR_XP10_DECOMP_FHP_STATS_EN
   logic [31:0] stat_hdr_q, stat_hdr_d, stat_err_q, stat_err_d, stat_word_q, stat_word_d;

   always_comb begin
      stat_hdr_d  = stat_hdr_q + 32'(hdr_vld_q);
      stat_err_d  = stat_err_q + 32'(err_q);
      stat_word_d = stat_word_q + 32'(skid_valid & fhp_out_ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_hdr_q  <= '0;
         stat_err_q  <= '0;
         stat_word_q <= '0;
      end else begin
         stat_hdr_q  <= stat_hdr_d;
         stat_err_q  <= stat_err_d;
         stat_word_q <= stat_word_d;
      end
   end

   assign fhp_stat_hdr_cnt  = stat_hdr_q;
   assign fhp_stat_err_cnt  = stat_err_q;
   assign fhp_stat_word_cnt = stat_word_q;
`endif

endmodule

// File: tb/tb_cr_xp10_decomp_fhp_tlv_rdr.sv
// Table-driven bench for the FHP TLV reader with a show-ahead source model and an output scoreboard.
module tb_cr_xp10_decomp_fhp_tlv_rdr;
   import cr_structs::*;

   typedef struct {
      logic         sot;
      logic         eot;
      logic [7:0]   typ;
      logic [63:0]  data;
      bit           fwd;
      bit           err;
      bit           hv;
      logic [127:0] hdr;
   } vec_t;

   typedef struct {
      logic [73:0] bus;
      int          pop_cyc;
      bit          lat_chk;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   tlvp_if_bus_t tlv = '0;
   logic         empty = 1'b1;
   logic         ready = 1'b1;
   logic         rd, valid, o_sot, o_eot, hv, perr;
   logic [63:0]  o_data;
   logic [7:0]   o_type;
   logic [127:0] hdr;
`ifdef CR_XP10_DECOMP_FHP_STATS_EN
   logic [31:0]  stat_hdr, stat_err, stat_word;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int occ   = 0;
   int ready_mode = 0;
   int err_seen, hv_seen;
   bit pop_pend = 1'b0;
   bit prev_v = 1'b0;
   bit prev_r = 1'b0;
   logic [74:0] prev_bus = '0;

   vec_t         vt[64];
   int           nv = 0;
   int           np = 0;
   int           ph_lo[10];
   int           ph_n[10];
   int           ph_mode[10];
   vec_t         src[$];
   exp_t         exp_q[$];
   logic [127:0] hdr_q[$];

   cr_xp10_decomp_fhp_tlv_rdr dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .fhp_tlvp_pt_tlv   (tlv),
      .fhp_tlvp_pt_empty (empty),
      .fhp_tlvp_pt_rd    (rd),
      .fhp_out_valid     (valid),
      .fhp_out_ready     (ready),
      .fhp_out_data      (o_data),
      .fhp_out_sot       (o_sot),
      .fhp_out_eot       (o_eot),
      .fhp_out_type      (o_type),
      .fhp_frm_hdr       (hdr),
      .fhp_frm_hdr_valid (hv),
      .fhp_proto_error   (perr)
`ifdef CR_XP10_DECOMP_FHP_STATS_EN
      ,
      .fhp_stat_hdr_cnt  (stat_hdr),
      .fhp_stat_err_cnt  (stat_err),
      .fhp_stat_word_cnt (stat_word)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic s, input logic e, input logic [7:0] t, input logic [63:0] d,
                      input bit f, input bit er, input bit h, input logic [127:0] hd);
      vt[nv].sot  = s;
      vt[nv].eot  = e;
      vt[nv].typ  = t;
      vt[nv].data = d;
      vt[nv].fwd  = f;
      vt[nv].err  = er;
      vt[nv].hv   = h;
      vt[nv].hdr  = hd;
      nv++;
   endtask

   task automatic new_phase(input int mode);
      if (np > 0) ph_n[np-1] = nv - ph_lo[np-1];
      ph_lo[np]   = nv;
      ph_mode[np] = mode;
      np++;
   endtask

   task automatic chk_all_zero(input string tag);
      check({tag, "_rd"},    rd,     0);
      check({tag, "_valid"}, valid,  0);
      check({tag, "_data"},  o_data, 0);
      check({tag, "_sot"},   o_sot,  0);
      check({tag, "_eot"},   o_eot,  0);
      check({tag, "_type"},  o_type, 0);
      check({tag, "_hdr"},   hdr,    0);
      check({tag, "_hv"},    hv,     0);
      check({tag, "_err"},   perr,   0);
   endtask

   // Source FIFO model and output monitor: sample at negedge, update inputs 1ns after posedge.
   always begin
      bit   hs, pushed;
      exp_t e;
      @(negedge clk);
      if (!rst_n) begin
         pop_pend = 1'b0;
         prev_v   = 1'b0;
         occ      = 0;
         exp_q.delete();
      end else begin
         hs     = valid && ready;
         pushed = 1'b0;
         if (prev_v && !prev_r)
            check("out_hold", {valid, o_data, o_sot, o_eot, o_type}, prev_bus);
         if (hs) begin
            check("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("out_word", {o_data, o_sot, o_eot, o_type}, e.bus);
               if (e.lat_chk) check("out_lat", cyc - e.pop_cyc, 1);
            end
         end
         if (hv) begin
            hv_seen++;
            check("hdr_expected", hdr_q.size() != 0, 1);
            if (hdr_q.size() != 0) check("hdr_val", hdr, hdr_q.pop_front());
         end
         if (perr) err_seen++;
         pop_pend = rd;
         if (rd) begin
            check("rd_src", src.size() != 0, 1);
            if (src.size() != 0 && src[0].fwd) begin
               check("rd_full", occ >= 2, 0);
               e.bus     = {src[0].data, src[0].sot, src[0].eot, src[0].typ};
               e.pop_cyc = cyc;
               e.lat_chk = (ready_mode == 0);
               exp_q.push_back(e);
               pushed = 1'b1;
            end
         end
         occ      = occ + int'(pushed) - int'(hs);
         prev_v   = valid;
         prev_r   = ready;
         prev_bus = {valid, o_data, o_sot, o_eot, o_type};
      end
      @(posedge clk);
      cyc++;
      #1;
      if (pop_pend && src.size() != 0) src.delete(0);
      empty = (src.size() == 0);
      if (src.size() != 0) begin
         tlv.sot   = src[0].sot;
         tlv.eot   = src[0].eot;
         tlv.typen = src[0].typ;
         tlv.tdata = src[0].data;
      end else begin
         tlv = '0;
      end
      case (ready_mode)
         0:       ready = 1'b1;
         1:       ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         default: ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic run_phase(input int p);
      int err_exp = 0;
      int hv_exp  = 0;
      bit done    = 1'b0;
      @(posedge clk);
      #2;
      ready_mode = ph_mode[p];
      err_seen   = 0;
      hv_seen    = 0;
      for (int i = ph_lo[p]; i < ph_lo[p] + ph_n[p]; i++) begin
         src.push_back(vt[i]);
         err_exp += int'(vt[i].err);
         if (vt[i].hv) begin
            hdr_q.push_back(vt[i].hdr);
            hv_exp++;
         end
      end
      for (int k = 0; k < 400 && !done; k++) begin
         @(posedge clk);
         #2;
         done = (src.size() == 0) && (exp_q.size() == 0) && (occ == 0);
      end
      check($sformatf("drain_p%0d", p), done, 1);
      repeat (3) @(posedge clk);
      #2;
      check($sformatf("err_cnt_p%0d", p), err_seen, err_exp);
      check($sformatf("hv_cnt_p%0d", p), hv_seen, hv_exp);
      check($sformatf("hdr_left_p%0d", p), hdr_q.size(), 0);
      ready_mode = 0;
   endtask

   initial begin
      vec_t w;
      bit   got;
      rst_n = 1'b0;

      // A: 3-word type-2 TLV, ready held high
      new_phase(0);
      add(1, 0, 8'd2, 64'h100, 1, 0, 0, '0);
      add(0, 0, 8'd2, 64'h101, 1, 0, 0, '0);
      add(0, 1, 8'd2, 64'h102, 1, 0, 0, '0);
      // B: well-formed header
      new_phase(0);
      add(1, 0, 8'd5, 64'h55, 0, 0, 0, '0);
      add(0, 0, 8'd5, 64'hA,  0, 0, 0, '0);
      add(0, 1, 8'd5, 64'hB,  0, 0, 1, {64'hB, 64'hA});
      // C: header ending after one data word, then a normal single-word TLV
      new_phase(0);
      add(1, 0, 8'd5, 64'h0,  0, 0, 0, '0);
      add(0, 1, 8'd5, 64'hC1, 0, 1, 0, '0);
      add(1, 1, 8'd2, 64'h77, 1, 0, 0, '0);
      // D: 8-word TLV under ready pattern 1,0,0,1
      new_phase(1);
      for (int k = 0; k < 8; k++)
         add(k == 0, k == 7, 8'd7, 64'h700 + 64'(k), 1, 0, 0, '0);
      // E: sot arriving mid-FWD
      new_phase(0);
      add(1, 0, 8'd2, 64'h200, 1, 0, 0, '0);
      add(0, 0, 8'd2, 64'h201, 1, 0, 0, '0);
      add(1, 0, 8'd3, 64'h300, 1, 1, 0, '0);
      add(0, 1, 8'd3, 64'h301, 1, 0, 0, '0);
      // F: header with a third data word, dropped to eot
      new_phase(0);
      add(1, 0, 8'd5, 64'h5,  0, 0, 0, '0);
      add(0, 0, 8'd5, 64'hA1, 0, 0, 0, '0);
      add(0, 0, 8'd5, 64'hB1, 0, 1, 0, '0);
      add(0, 0, 8'd5, 64'hC1, 0, 0, 0, '0);
      add(0, 1, 8'd5, 64'hD1, 0, 0, 0, '0);
      add(1, 1, 8'd4, 64'h44, 1, 0, 0, '0);
      // G: framing corner cases under random ready
      new_phase(2);
      add(0, 0, 8'd9, 64'h91, 0, 1, 0, '0);
      add(0, 1, 8'd9, 64'h92, 0, 0, 0, '0);
      add(0, 1, 8'd9, 64'h93, 0, 1, 0, '0);
      add(1, 0, 8'd9, 64'h94, 1, 0, 0, '0);
      add(0, 1, 8'd9, 64'h95, 1, 0, 0, '0);
      add(1, 1, 8'd5, 64'h96, 0, 1, 0, '0);
      add(1, 0, 8'd5, 64'h0,  0, 0, 0, '0);
      add(0, 0, 8'd5, 64'hE1, 0, 0, 0, '0);
      add(1, 0, 8'd5, 64'h0,  0, 1, 0, '0);
      add(0, 0, 8'd5, 64'hE2, 0, 0, 0, '0);
      add(0, 1, 8'd5, 64'hE3, 0, 0, 1, {64'hE3, 64'hE2});
      add(1, 0, 8'd2, 64'h97, 1, 0, 0, '0);
      add(1, 0, 8'd5, 64'h0,  0, 1, 0, '0);
      add(0, 0, 8'd5, 64'hF2, 0, 0, 0, '0);
      add(0, 1, 8'd5, 64'hF3, 0, 0, 1, {64'hF3, 64'hF2});
      // H: header sent after a mid-header reset
      new_phase(0);
      add(1, 0, 8'd5, 64'h0,    0, 0, 0, '0);
      add(0, 0, 8'd5, 64'h1234, 0, 0, 0, '0);
      add(0, 1, 8'd5, 64'h5678, 0, 0, 1, {64'h5678, 64'h1234});
      ph_n[np-1] = nv - ph_lo[np-1];

      repeat (3) @(posedge clk);
      #3;
      chk_all_zero("rst");
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      for (int p = 0; p < np - 1; p++) run_phase(p);

      // Mid-header reset: assert while the header data word is being presented.
      @(posedge clk);
      #2;
      w = vt[ph_lo[np-1]];
      src.push_back(w);
      w.data = 64'hAAAA;
      src.push_back(w);
      w.data = 64'hBBBB;
      w.eot  = 1'b1;
      src.push_back(w);
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(posedge clk);
         #2;
         got = (src.size() <= 2);
      end
      check("midrst_reach", got, 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      src.delete();
      hdr_q.delete();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      run_phase(np - 1);
      check("hdr_after_rst", hdr, {64'h5678, 64'h1234});

`ifdef CR_XP10_DECOMP_FHP_STATS_EN
      check("stat_hdr",  stat_hdr,  1);
      check("stat_err",  stat_err,  0);
      check("stat_word", stat_word, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
